// File: rtl/cordic_phase_seq.sv
// cordic_phase_seq: phase accumulator, quadrant fold and sign correction around cordic_top.
// Optional PHASE_DITHER_EN adds LFSR LSB dither to the issued phase.
module cordic_phase_seq #(
  parameter int W   = 18,
  parameter int PW  = 18,
  parameter int AMP = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] ftw,
  output logic          cordic_start,
  output logic [W-1:0]  cordic_x0,
  output logic [W-1:0]  cordic_y0,
  output logic [PW-1:0] cordic_z0,
  input  logic          cordic_done,
  input  logic [W-1:0]  cordic_xn,
  input  logic [W-1:0]  cordic_yn,
  output logic [W-1:0]  cos_out,
  output logic [W-1:0]  sin_out,
  output logic          valid
);
  localparam logic [PW-1:0] Q1   = PW'(1) << (PW-2);
  localparam logic [PW-1:0] HALF = PW'(1) << (PW-1);
  localparam logic [PW-1:0] Q3   = Q1 + HALF;
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, z0_q, z0_d, p, fold_z;
  logic          neg_q, neg_d, fold_neg;
  logic [W-1:0]  cos_q, cos_d, sin_q, sin_d;
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
    return v == SMIN ? SMAX : -v;
  endfunction
`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign p = phase_q + PW'(lfsr_q[0]);
  assign lfsr_d = state_q == ISSUE ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
`else
  assign p = phase_q;
`endif
  // Second and third quadrants rotate by pi and get their result negated afterwards.
  assign fold_neg     = p >= Q1 && p < Q3;
  assign fold_z       = fold_neg ? p - HALF : p;
  assign cordic_start = state_q == ISSUE;
  assign cordic_z0    = state_q == ISSUE ? fold_z : z0_q;
  assign cordic_x0    = W'(AMP);
  assign cordic_y0    = '0;
  assign cos_out      = cos_q;
  assign sin_out      = sin_q;
  assign valid        = state_q == OUT;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    z0_d    = z0_q;
    neg_d   = neg_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE:  state_d = enable ? ISSUE : IDLE;
      ISSUE: begin
        z0_d    = fold_z;
        neg_d   = fold_neg;
        phase_d = phase_q + ftw;
        state_d = WAIT;
      end
      WAIT:  if (cordic_done) begin
        cos_d   = neg_q ? neg_sat(cordic_xn) : cordic_xn;
        sin_d   = neg_q ? neg_sat(cordic_yn) : cordic_yn;
        state_d = OUT;
      end
      OUT:   state_d = enable ? ISSUE : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      z0_q    <= '0;
      neg_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      z0_q    <= z0_d;
      neg_q   <= neg_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
endmodule

// File: tb/tb_cordic_phase_seq.sv
// tb_cordic_phase_seq: randomized bench with a fixed-latency CORDIC stand-in and a phase/fold/correction model.
module tb_cordic_phase_seq;
  localparam int W = 18, PW = 18, LAT = 20;
  logic clk = 0, rst, enable, done_f, done_m = 0, cordic_done;
  logic [PW-1:0] ftw, cordic_z0;
  logic [W-1:0] xn_v, yn_v, cordic_x0, cordic_y0, cos_out, sin_out;
  logic cordic_start, valid;
  int cnt = 0, ph = 0, pass_n = 0, tot = 0;
  logic [15:0] lf = 16'hACE1;
  cordic_phase_seq #(.W(W), .PW(PW), .AMP(50000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ftw(ftw), .cordic_start(cordic_start),
    .cordic_x0(cordic_x0), .cordic_y0(cordic_y0), .cordic_z0(cordic_z0), .cordic_done(cordic_done),
    .cordic_xn(xn_v), .cordic_yn(yn_v), .cos_out(cos_out), .sin_out(sin_out), .valid(valid));
  always #5 clk = ~clk;
  assign cordic_done = done_m | done_f;
  always @(posedge clk) begin
    done_m <= 0;
    if (cordic_start) cnt <= LAT;
    else if (cnt == 1) begin done_m <= 1; cnt <= 0; end
    else if (cnt > 1) cnt <= cnt - 1;
  end
  function automatic int sx(input logic [17:0] v);
    return int'($signed(v));
  endfunction
  function automatic int corr(input int v, input bit n);
    return n ? (v == -131072 ? 131071 : -v) : v;
  endfunction
  task automatic model_issue(output int z, output bit n);
    int p = ph;
`ifdef PHASE_DITHER_EN
    p = (p + int'(lf[0])) % 262144;
    lf = lf[0] ? ({1'b0, lf[15:1]} ^ 16'hB400) : {1'b0, lf[15:1]};
`endif
    n = p >= 65536 && p < 196608;
    z = n ? p - 131072 : (p >= 131072 ? p - 262144 : p);
    ph = (ph + int'(ftw)) % 262144;
  endtask
  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cordic_start === 1'b1) begin ok = 1; return; end
    end
  endtask
  task automatic wait_valid(output bit ok, output bit dp);
    bit d = 0;
    ok = 0; dp = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin ok = 1; dp = d; return; end
      d = cordic_done;
    end
  endtask
  task automatic do_reset;
    rst = 1; enable = 0; done_f = 0;
    repeat (2) @(negedge clk);
    rst = 0; ph = 0; lf = 16'hACE1;
  endtask
  task automatic test_reset;
    bit bad = 0;
    rst = 1; enable = 0; done_f = 0; ftw = 0; xn_v = 0; yn_v = 0;
    repeat (2) @(negedge clk);
    tot++;
    if ({cordic_start, valid} === 2'b00 && cordic_z0 === 0 && cos_out === 0 && sin_out === 0) pass_n++;
    else $display("FAIL reset_outputs: start=%b valid=%b z0=%0d cos=%0d sin=%0d, required all 0", cordic_start, valid, cordic_z0, cos_out, sin_out);
    tot++;
    if (cordic_x0 === 18'd50000 && cordic_y0 === 0) pass_n++;
    else $display("FAIL reset_x0y0: x0=%0d y0=%0d, required 50000/0", cordic_x0, cordic_y0);
    rst = 0; ph = 0; lf = 16'hACE1;
    done_f = 1; @(negedge clk); done_f = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (valid !== 1'b0 || cordic_start !== 1'b0) bad = 1; end
    tot++;
    if (!bad) pass_n++;
    else $display("FAIL idle_done_ignored: saw valid/start while idle, required none");
  endtask
  task automatic test_sequence(input logic [PW-1:0] f, input int n);
    bit ok, dp, en, bad = 0;
    int ez, xv, yv;
    ftw = f; enable = 1;
    for (int k = 0; k < n; k++) begin
      wait_start(ok);
      tot++;
      if (!ok) begin $display("FAIL seq_start_timeout: sample %0d got no start, required one", k); enable = 0; return; end
      model_issue(ez, en);
      if (k == n - 1) enable = 0;
      if (sx(cordic_z0) === ez) pass_n++;
      else $display("FAIL seq_z0: sample %0d z0=%0d, required %0d", k, sx(cordic_z0), ez);
      xv = $urandom_range(0, 7) == 0 ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      yv = $urandom_range(0, 7) == 0 ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      xn_v = xv[17:0]; yn_v = yv[17:0];
      wait_valid(ok, dp);
      tot++;
      if (ok && dp && sx(cos_out) === corr(xv, en) && sin_out === 18'(corr(yv, en))) pass_n++;
      else $display("FAIL seq_out: sample %0d ok=%b done_prev=%b cos=%0d sin=%0d, required cos=%0d sin=%0d", k, ok, dp, sx(cos_out), sx(sin_out), corr(xv, en), corr(yv, en));
    end
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (cordic_start !== 1'b0 || valid !== 1'b0) bad = 1; end
    tot++;
    if (!bad) pass_n++;
    else $display("FAIL seq_stop: activity after enable dropped, required idle");
  endtask
  task automatic test_saturation;
    bit ok, dp, en, bad = 0;
    int ez;
    int xs[3] = '{123, 1000, -131072};
    int ys[3] = '{-456, -2000, -131072};
    do_reset;
    ftw = 18'd65536; enable = 1;
    for (int k = 0; k < 3; k++) begin
      wait_start(ok);
      tot++;
      if (!ok) begin $display("FAIL sat_start_timeout: sample %0d got no start, required one", k); enable = 0; return; end
      model_issue(ez, en);
      if (sx(cordic_z0) === ez) pass_n++;
      else $display("FAIL sat_z0: sample %0d z0=%0d, required %0d", k, sx(cordic_z0), ez);
      xn_v = xs[k][17:0]; yn_v = ys[k][17:0];
      if (k == 2) begin @(negedge clk); enable = 0; end
      wait_valid(ok, dp);
      tot++;
      if (ok && dp && sx(cos_out) === corr(xs[k], en) && sx(sin_out) === corr(ys[k], en)) pass_n++;
      else $display("FAIL sat_out: sample %0d ok=%b done_prev=%b cos=%0d sin=%0d, required cos=%0d sin=%0d", k, ok, dp, sx(cos_out), sx(sin_out), corr(xs[k], en), corr(ys[k], en));
    end
    @(negedge clk);
    tot++;
    if (valid === 1'b0) pass_n++;
    else $display("FAIL valid_width: valid=%b two cycles running, required 0", valid);
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (cordic_start !== 1'b0 || valid !== 1'b0) bad = 1; end
    tot++;
    if (!bad) pass_n++;
    else $display("FAIL drop_enable: activity after late enable drop, required idle");
  endtask
  task automatic test_wrap;
    bit ok, dp, en, bad = 0;
    int ez;
    do_reset;
    ftw = 18'd262000; enable = 1;
    wait_start(ok);
    model_issue(ez, en);
    xn_v = 18'd777; yn_v = 18'd0;
    wait_valid(ok, dp);
    ftw = 18'd1000;
    for (int k = 0; k < 2; k++) begin
      wait_start(ok);
      tot++;
      if (!ok) begin $display("FAIL wrap_start_timeout: sample %0d got no start, required one", k); enable = 0; return; end
      model_issue(ez, en);
      if (sx(cordic_z0) === ez) pass_n++;
      else $display("FAIL wrap_z0: sample %0d z0=%0d, required %0d", k, sx(cordic_z0), ez);
      if (k == 0) wait_valid(ok, dp);
    end
    repeat (5) @(negedge clk);
    rst = 1; enable = 0;
    @(negedge clk);
    tot++;
    if ({cordic_start, valid} === 2'b00 && cordic_z0 === 0 && cos_out === 0 && sin_out === 0) pass_n++;
    else $display("FAIL mid_reset: start=%b valid=%b z0=%0d cos=%0d sin=%0d, required all 0", cordic_start, valid, cordic_z0, cos_out, sin_out);
    rst = 0; ph = 0; lf = 16'hACE1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (cordic_start !== 1'b0 || valid !== 1'b0) bad = 1; end
    tot++;
    if (!bad) pass_n++;
    else $display("FAIL late_done: activity after reset, required idle");
  endtask
  initial begin
    test_reset;
    test_sequence(18'd16384, 8);
    test_saturation;
    test_wrap;
    do_reset;
    test_sequence(18'd0, 4);
    test_sequence(18'($urandom), 6);
    test_sequence(18'($urandom), 6);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
